// File: rtl/alu_stage_pipe.sv
// alu_stage_pipe: single-stage ALU with a registered result and valid/ready
// handshakes on both sides. Most ops produce their result in one cycle. MUL
// uses a shift-add multiplier that handles one multiplier bit per cycle.
module alu_stage_pipe #(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] RF_A,
   input  logic [WIDTH-1:0] RF_B,
   input  logic [WIDTH-1:0] Immed,
   input  logic [1:0]       B_sel,
   input  logic [3:0]       ALU_func,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] ALU_out,
   output logic             Zero,
   output logic             Ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             state_dbg
);

   // Handshake: a request is accepted on a rising edge where in_valid and
   // in_ready are both high. A result is consumed on a rising edge where
   // out_valid and out_ready are both high. While out_valid is high and
   // out_ready is low, the result stays frozen and no request is accepted.

   typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_NOT  = 4'b0100;
   localparam logic [3:0] OP_NAND = 4'b0101;
   localparam logic [3:0] OP_NOR  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SLL  = 4'b1010;
   localparam logic [3:0] OP_ROL  = 4'b1100;
   localparam logic [3:0] OP_ROR  = 4'b1101;
   localparam logic [3:0] OP_MUL  = 4'b1110;

   state_t           state;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] res;
   logic             res_ovf;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             is_mul;
   logic             accept;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic [WIDTH-1:0] mul_acc;
   logic [WIDTH-1:0] mul_acc_next;
   logic [CNT_W-1:0] mul_cnt;

   assign in_ready     = (state == IDLE) && (!out_valid || out_ready);
   assign accept       = in_valid && in_ready;
   assign is_mul       = MUL_EN && (ALU_func == OP_MUL);
   assign state_dbg    = (state == MUL_BUSY);
   assign sum          = RF_A + op_b;
   assign diff         = RF_A - op_b;
   assign mul_acc_next = mul_acc + (mul_b[0] ? mul_a : '0);

   // Select the B operand.
   always_comb begin
      op_b = '0;
      case (B_sel)
         2'b00:   op_b = RF_B;
         2'b01:   op_b = Immed;
         2'b10:   op_b = Immed << (WIDTH / 2);
         default: op_b = '0;
      endcase
   end

   // Compute the single-cycle result. Undefined codes, and MUL when it is
   // disabled, fall through to zero.
   always_comb begin
      res     = '0;
      res_ovf = 1'b0;
      case (ALU_func)
         OP_ADD: begin
            res     = sum;
            res_ovf = (RF_A[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != RF_A[WIDTH-1]);
         end
         OP_SUB: begin
            res     = diff;
            res_ovf = (RF_A[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != RF_A[WIDTH-1]);
         end
         OP_AND:  res = RF_A & op_b;
         OP_OR:   res = RF_A | op_b;
         OP_NOT:  res = ~RF_A;
         OP_NAND: res = ~(RF_A & op_b);
         OP_NOR:  res = ~(RF_A | op_b);
         OP_SRA:  res = {RF_A[WIDTH-1], RF_A[WIDTH-1:1]};
         OP_SRL:  res = {1'b0, RF_A[WIDTH-1:1]};
         OP_SLL:  res = {RF_A[WIDTH-2:0], 1'b0};
         OP_ROL:  res = {RF_A[WIDTH-2:0], RF_A[WIDTH-1]};
         OP_ROR:  res = {RF_A[0], RF_A[WIDTH-1:1]};
         default: res = '0;
      endcase
   end

   // Control FSM, multiplier datapath and output registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= IDLE;
         ALU_out   <= '0;
         Zero      <= 1'b0;
         Ovf       <= 1'b0;
         out_valid <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_acc   <= '0;
         mul_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     // The old result (if any) drains here; no result is
                     // presented until the multiply completes.
                     state     <= MUL_BUSY;
                     mul_a     <= RF_A;
                     mul_b     <= op_b;
                     mul_acc   <= '0;
                     mul_cnt   <= '0;
                     out_valid <= 1'b0;
                  end else begin
                     ALU_out   <= res;
                     Zero      <= (res == '0);
                     Ovf       <= res_ovf;
                     out_valid <= 1'b1;
                  end
               end else if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            MUL_BUSY: begin
               mul_acc <= mul_acc_next;
               mul_a   <= {mul_a[WIDTH-2:0], 1'b0};
               mul_b   <= {1'b0, mul_b[WIDTH-1:1]};
               mul_cnt <= mul_cnt + CNT_W'(1);
               if (mul_cnt == CNT_LAST) begin
                  ALU_out   <= mul_acc_next;
                  Zero      <= (mul_acc_next == '0);
                  Ovf       <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_stage_pipe.md
ALU_STAGE_PIPE -- requirements
Module: alu_stage_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; even, >= 8.
REQ-002 Parameter MUL_EN, default 1, enables the multicycle MUL operation; 0 means MUL is treated as an undefined op.
REQ-003 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 RF_A  input  WIDTH  operand A.
REQ-006 RF_B  input  WIDTH  register operand B.
REQ-007 Immed  input  WIDTH  sign/zero-extended immediate, already extended by decode.
REQ-008 B_sel  input  2  B source: 00 RF_B, 01 Immed, 10 Immed shifted left by WIDTH/2 (LUI), 11 all-zero.
REQ-009 ALU_func  input  4  operation code.
REQ-010 in_valid  input  1  operation request present.
REQ-011 in_ready  output  1  stage accepts a request this cycle.
REQ-012 ALU_out  output  WIDTH  registered result.
REQ-013 Zero  output  1  registered, ALU_out == 0.
REQ-014 Ovf  output  1  registered signed overflow.
REQ-015 out_valid  output  1  ALU_out, Zero and Ovf hold a result.
REQ-016 out_ready  input  1  consumer takes the result this cycle.

Function
REQ-017 Accept happens when in_valid and in_ready are both high on a rising edge. Operands, B_sel and ALU_func are sampled only at accept.
REQ-018 Ops: 0000 ADD, 0001 SUB (A-B), 0010 AND, 0011 OR, 0100 NOT A, 0101 NAND, 0110 NOR, 1000 SRA by 1, 1001 SRL by 1, 1010 SLL by 1, 1100 ROL by 1, 1101 ROR by 1, 1110 MUL (low WIDTH bits of the unsigned product).
REQ-019 Any other code gives ALU_out 0, Zero 1, Ovf 0, with single-cycle latency.
REQ-020 Ovf is set only for ADD/SUB two's-complement overflow (operand sign rule); it is 0 for all other ops.
REQ-021 FSM states: IDLE, MUL_BUSY.
- Reset enters IDLE.
- IDLE -> MUL_BUSY on accept of MUL when MUL_EN=1.
- MUL_BUSY -> IDLE after WIDTH iterations.
REQ-022 in_ready = (state == IDLE) and (out_valid == 0 or out_ready == 1).
REQ-023 Single-cycle ops: result registered at the accept edge; out_valid high from the next cycle (latency 1).
REQ-024 MUL is a shift-add multiplier, one bit per cycle. The result is registered after WIDTH cycles in MUL_BUSY, so out_valid rises WIDTH+1 cycles after accept; in_ready stays low throughout.
REQ-025 out_valid clears on a cycle where out_valid and out_ready are high and no new result is registered.
REQ-026 If out_valid is high and out_ready is low, ALU_out, Zero, Ovf and out_valid stay frozen and no accept occurs.
REQ-027 Drain and accept in the same cycle of a single-cycle op: the new result replaces the old one at that edge and out_valid stays 1 (back-to-back throughput of 1 per cycle).
REQ-028 Drain and accept in the same cycle of MUL: out_valid falls to 0 for the whole MUL_BUSY period.
REQ-029 in_valid during MUL_BUSY is ignored. Input changes outside accept have no effect.
REQ-030 MUL operand width and shift/rotate wrap follow WIDTH: ROL moves bit WIDTH-1 into bit 0; ROR moves bit 0 into bit WIDTH-1.

Reset
REQ-031 Reset_n low asynchronously forces state IDLE, out_valid 0, ALU_out 0, Zero 0, Ovf 0, and clears the multiplier registers.
REQ-032 Reset asserted mid-MUL aborts the multiply with no result delivered; in_ready is 1 in the first cycle after release.

Verification
REQ-033 WIDTH=32: ADD A=0x7FFFFFFF, B_sel=00, RF_B=1, out_ready=1 -> next cycle out_valid=1, ALU_out=0x80000000, Ovf=1, Zero=0.
REQ-034 SUB A=5, B_sel=01, Immed=5 -> ALU_out=0, Zero=1, Ovf=0; then B_sel=10, Immed=0x1234, func OR, A=0 -> ALU_out=0x12340000.
REQ-035 MUL A=0x10001, RF_B=3 -> in_ready low 32 cycles, out_valid at accept+33, ALU_out=0x30003; in_valid pulsed mid-multiply is not accepted.
REQ-036 Back-to-back ROL/ROR with out_ready held 0 for 3 cycles -> result frozen, in_ready=0; on release, 1 result per cycle; ROL 0x80000001 -> 0x00000003.
REQ-037 Reset_n pulsed low at cycle 10 of a MUL -> outputs 0 immediately, no out_valid, in_ready=1 after release; WIDTH=16 rerun of REQ-033 with 0x7FFF -> 0x8000, Ovf=1.
